// File: rtl/data_mem_controller.sv
// Data-memory responder: arbitrates per-LSU read/write requests onto a small
// pool of memory channels and relays each response back to the requesting LSU.
module data_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]          consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]          consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]           mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  input  logic [NUM_CHANNELS-1:0]           mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
  } state_t;

  state_t                           state_q [NUM_CHANNELS];
  state_t                           state_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]         claimed_q, claimed_d;
  logic [NUM_CHANNELS-1:0][CW-1:0]  cur_q, cur_d;

  logic [NUM_CONSUMERS-1:0]           rd_ready_d, wr_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_d;
  logic [NUM_CHANNELS-1:0]            mrv_d, mwv_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mra_d, mwa_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mwd_d;

  always_comb begin : next_state
    logic found;
    int   cc;
    found      = 1'b0;
    cc         = 0;
    state_d    = state_q;
    claimed_d  = claimed_q;
    cur_d      = cur_q;
    rd_ready_d = consumer_read_ready;
    rd_data_d  = consumer_read_data;
    wr_ready_d = consumer_write_ready;
    mrv_d      = mem_read_valid;
    mra_d      = mem_read_address;
    mwv_d      = mem_write_valid;
    mwa_d      = mem_write_address;
    mwd_d      = mem_write_data;

    // Channels walk in index order against the running claimed mask, so a
    // consumer taken by a lower channel this cycle is invisible to higher ones.
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      found = 1'b0;
      cc    = int'(cur_q[ch]);
      case (state_q[ch])
        IDLE: begin
          for (int c = 0; c < NUM_CONSUMERS; c++) begin
            if (!found && !claimed_d[c] &&
                (consumer_read_valid[c] || consumer_write_valid[c])) begin
              found        = 1'b1;
              claimed_d[c] = 1'b1;
              cur_d[ch]    = CW'(c);
              if (consumer_read_valid[c]) begin
                mrv_d[ch] = 1'b1;
                mra_d[ch*ADDR_BITS +: ADDR_BITS] = consumer_read_address[c*ADDR_BITS +: ADDR_BITS];
                state_d[ch] = READ_WAITING;
              end else begin
                mwv_d[ch] = 1'b1;
                mwa_d[ch*ADDR_BITS +: ADDR_BITS] = consumer_write_address[c*ADDR_BITS +: ADDR_BITS];
                mwd_d[ch*DATA_BITS +: DATA_BITS] = consumer_write_data[c*DATA_BITS +: DATA_BITS];
                state_d[ch] = WRITE_WAITING;
              end
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            mrv_d[ch]      = 1'b0;
            rd_ready_d[cc] = 1'b1;
            rd_data_d[cc*DATA_BITS +: DATA_BITS] = mem_read_data[ch*DATA_BITS +: DATA_BITS];
            state_d[ch]    = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[ch]) begin
            mwv_d[ch]      = 1'b0;
            wr_ready_d[cc] = 1'b1;
            state_d[ch]    = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[cc]) begin
            rd_ready_d[cc] = 1'b0;
            claimed_d[cc]  = 1'b0;
            state_d[ch]    = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[cc]) begin
            wr_ready_d[cc] = 1'b0;
            claimed_d[cc]  = 1'b0;
            state_d[ch]    = IDLE;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= IDLE;
      claimed_q            <= '0;
      cur_q                <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      state_q              <= state_d;
      claimed_q            <= claimed_d;
      cur_q                <= cur_d;
      consumer_read_ready  <= rd_ready_d;
      consumer_read_data   <= rd_data_d;
      consumer_write_ready <= wr_ready_d;
      mem_read_valid       <= mrv_d;
      mem_read_address     <= mra_d;
      mem_write_valid      <= mwv_d;
      mem_write_address    <= mwa_d;
      mem_write_data       <= mwd_d;
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Scoreboard bench for data_mem_controller: LSU drivers push expected
// responses, a memory model answers channels, a monitor pops and compares.
module tb_data_mem_controller;
  localparam int AB = 8, DB = 8, NC = 4, NCH = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0]     rv, wv, rr, wr;
  logic [NC*AB-1:0]  ra, wa;
  logic [NC*DB-1:0]  wd, rd;
  logic [NCH-1:0]    mrv, mrr, mwv, mwr;
  logic [NCH*AB-1:0] mra, mwa;
  logic [NCH*DB-1:0] mrd, mwd;

  always #5 clk = ~clk;

  data_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(rr), .consumer_read_data(rd),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(wr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  int n_chk = 0, n_fail = 0;
  logic [7:0]  rom [256];
  logic [7:0]  exp_rd [NC][$];
  logic [15:0] exp_wr [NC][$];
  logic [15:0] obs_wr [$];
  int fixed_lat = 2;
  int hr [NC];
  int hw [NC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat();
    return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3));
  endfunction

  // LSU side: drop valid some cycles after ready is seen
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < NC; i++) begin
      if (rv[i] && rr[i]) begin if (hr[i] == 0) rv[i] = 1'b0; else hr[i]--; end
      if (wv[i] && wr[i]) begin if (hw[i] == 0) wv[i] = 1'b0; else hw[i]--; end
    end
  endtask

  // kind: 0 read, 1 write, 2 read+write
  task automatic issue(input int i, input int kind, input logic [7:0] a_r,
                       input logic [7:0] a_w, input logic [7:0] d);
    if (kind != 1) begin
      ra[i*AB +: AB] = a_r; rv[i] = 1'b1;
      exp_rd[i].push_back(rom[a_r]);
      hr[i] = int'($urandom_range(2));
    end
    if (kind != 0) begin
      wa[i*AB +: AB] = a_w; wd[i*DB +: DB] = d; wv[i] = 1'b1;
      exp_wr[i].push_back({a_w, d});
      hw[i] = int'($urandom_range(2));
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (((rv | wv | rr | wr) != '0) && k < 300) begin tick(); k++; end
    chk({name, "_done"}, 32'(k < 300), 1);
    tick(); tick();
  endtask

  // Memory model: fixed read contents (rom), writes logged for the monitor
  initial begin : memory
    logic [NCH-1:0] rbusy, wbusy;
    int rcnt [NCH];
    int wcnt [NCH];
    logic [7:0] raddr [NCH];
    rbusy = '0; wbusy = '0; mrr = '0; mwr = '0; mrd = '0;
    for (int ch = 0; ch < NCH; ch++) begin rcnt[ch] = 0; wcnt[ch] = 0; raddr[ch] = '0; end
    forever begin
      @(posedge clk); #1;
      for (int ch = 0; ch < NCH; ch++) begin
        if (!reset) begin
          rbusy[ch] = 1'b0; wbusy[ch] = 1'b0; mrr[ch] = 1'b0; mwr[ch] = 1'b0;
        end else begin
          if (mrr[ch]) begin mrr[ch] = 1'b0; rbusy[ch] = 1'b0; end
          else begin
            if (!rbusy[ch] && mrv[ch]) begin
              rbusy[ch] = 1'b1; raddr[ch] = mra[ch*AB +: AB]; rcnt[ch] = lat();
            end
            if (rbusy[ch]) begin
              if (rcnt[ch] == 0) begin mrr[ch] = 1'b1; mrd[ch*DB +: DB] = rom[raddr[ch]]; end
              else rcnt[ch]--;
            end
          end
          if (mwr[ch]) begin mwr[ch] = 1'b0; wbusy[ch] = 1'b0; end
          else begin
            if (!wbusy[ch] && mwv[ch]) begin
              wbusy[ch] = 1'b1; wcnt[ch] = lat();
              obs_wr.push_back({mwa[ch*AB +: AB], mwd[ch*DB +: DB]});
            end
            if (wbusy[ch]) begin
              if (wcnt[ch] == 0) mwr[ch] = 1'b1;
              else wcnt[ch]--;
            end
          end
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a response
  initial begin : monitor
    logic [NC-1:0] prr, pwr, prv, pwv;
    logic [7:0]  e8;
    logic [15:0] e16;
    int idx;
    prr = '0; pwr = '0; prv = '0; pwv = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (rr[i] && !prr[i]) begin
          if (exp_rd[i].size() == 0) chk($sformatf("rd_spurious_c%0d", i), 1, 0);
          else begin
            e8 = exp_rd[i].pop_front();
            chk($sformatf("rd_data_c%0d", i), 32'(rd[i*DB +: DB]), 32'(e8));
          end
        end
        if (prr[i] && !prv[i]) chk($sformatf("rd_release_c%0d", i), 32'(rr[i]), 0);
        if (prr[i] && prv[i])  chk($sformatf("rd_hold_c%0d", i), 32'(rr[i]), 1);
        if (wr[i] && !pwr[i]) begin
          chk($sformatf("wr_after_rd_c%0d", i), 32'(rv[i]), 0);
          if (exp_wr[i].size() == 0) chk($sformatf("wr_spurious_c%0d", i), 1, 0);
          else begin
            e16 = exp_wr[i].pop_front();
            idx = -1;
            for (int k = 0; k < obs_wr.size(); k++) if (idx < 0 && obs_wr[k] == e16) idx = k;
            if (idx >= 0) obs_wr.delete(idx);
            chk($sformatf("wr_mem_c%0d_%04h", i, e16), 32'(idx >= 0), 1);
          end
        end
        if (pwr[i] && !pwv[i]) chk($sformatf("wr_release_c%0d", i), 32'(wr[i]), 0);
        if (pwr[i] && pwv[i])  chk($sformatf("wr_hold_c%0d", i), 32'(wr[i]), 1);
      end
      prr = rr; pwr = wr; prv = rv; pwv = wv;
    end
  end

  initial begin : main
    for (int k = 0; k < 256; k++) rom[k] = 8'($urandom_range(255));
    rom[8'h12] = 8'hAB;
    for (int i = 0; i < NC; i++) begin hr[i] = 0; hw[i] = 0; end
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0; reset = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 32'(|{rr, rd, wr, mrv, mra, mwv, mwa, mwd}), 0);
    reset = 1'b1; tick();

    // single read on consumer 0
    fixed_lat = 2;
    issue(0, 0, 8'h12, 8'h00, 8'h00); tick();
    chk("t1_mrv", 32'(mrv), 32'h1);
    chk("t1_addr", 32'(mra[AB-1:0]), 32'h12);
    wait_idle("t1");

    // single write on consumer 2
    fixed_lat = 1;
    issue(2, 1, 8'h00, 8'h40, 8'h5A); tick();
    chk("t2_mwv", 32'(mwv), 32'h1);
    chk("t2_waddr", 32'(mwa[AB-1:0]), 32'h40);
    chk("t2_wdata", 32'(mwd[DB-1:0]), 32'h5A);
    chk("t2_no_read", 32'({mrv, rr}), 0);
    wait_idle("t2");

    // two channels in parallel
    fixed_lat = 2;
    issue(1, 0, 8'h01, 8'h00, 8'h00); issue(3, 0, 8'h03, 8'h00, 8'h00); tick();
    chk("t3_mrv", 32'(mrv), 32'h3);
    chk("t3_addr", 32'(mra), 32'h0301);
    wait_idle("t3");

    // all four queue behind two channels
    fixed_lat = 3;
    for (int i = 0; i < NC; i++) issue(i, 0, 8'(8'h20 + i), 8'h00, 8'h00);
    tick();
    chk("t4_mrv", 32'(mrv), 32'h3);
    chk("t4_addr", 32'(mra), 32'h2120);
    wait_idle("t4");

    // read wins over write on the same consumer
    fixed_lat = 1;
    issue(0, 2, 8'h33, 8'h44, 8'hC3); tick();
    chk("t5_rd_first", 32'({mwv, mrv}), 32'h1);
    wait_idle("t5");

    // reset while waiting on memory
    fixed_lat = 3;
    issue(0, 0, 8'h77, 8'h00, 8'h00); tick();
    chk("t6_claim", 32'(mrv), 32'h1);
    reset = 1'b0; rv = '0; tick();
    chk("t6_reset_outputs", 32'(|{rr, rd, wr, mrv, mra, mwv, mwa, mwd}), 0);
    exp_rd[0].delete();
    tick(); tick();
    reset = 1'b1; tick();
    issue(0, 0, 8'h12, 8'h00, 8'h00);
    wait_idle("t6");

    // random traffic
    fixed_lat = -1;
    repeat (400) begin
      tick();
      for (int i = 0; i < NC; i++)
        if (!rv[i] && !wv[i] && !rr[i] && !wr[i] && $urandom_range(3) == 0)
          issue(i, int'($urandom_range(2)), 8'($urandom_range(255)),
                8'($urandom_range(255)), 8'($urandom_range(255)));
    end
    wait_idle("rand");

    for (int i = 0; i < NC; i++) begin
      chk($sformatf("rd_left_c%0d", i), 32'(exp_rd[i].size()), 0);
      chk($sformatf("wr_left_c%0d", i), 32'(exp_wr[i].size()), 0);
    end
    chk("wr_unclaimed", 32'(obs_wr.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
